// File: rtl/mskaes_io_pkg.sv
// Shared types and sizing for the masked-AES word-serial stream front/back end.
package mskaes_io_pkg;

  typedef enum logic [2:0] {
    LD_KEY = 3'd0,
    LD_PT  = 3'd1,
    START  = 3'd2,
    WAIT   = 3'd3,
    UNLOAD = 3'd4
  } io_state_e;

  function automatic int calc_nw(input int shares, input int word_w);
    return 128 * shares / word_w;
  endfunction

  localparam int D_DEF = 2;
  localparam int W_DEF = 32;
  localparam int NW    = calc_nw(D_DEF, W_DEF);
  localparam int CNT_W = $clog2(NW);

endpackage

// File: rtl/mskaes_word_reg.sv
// 128*d-bit share register: one W-bit word written per cycle at an index,
// with an optional full-width parallel load that takes priority.
module mskaes_word_reg
  import mskaes_io_pkg::*;
#(
  parameter int d = 2,
  parameter int W = 32,
  localparam int WN = calc_nw(d, W),
  localparam int CW = $clog2(WN)
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            wr_en,
  input  logic [CW-1:0]   wr_idx,
  input  logic [W-1:0]    wr_data,
  input  logic            ld_en,
  input  logic [128*d-1:0] ld_data,
  output logic [128*d-1:0] q
);

  logic [WN-1:0][W-1:0] words;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      words <= '0;
    end else begin
      for (int i = 0; i < WN; i++) begin
        if (ld_en)
          words[i] <= ld_data[W*i +: W];
        else if (wr_en && wr_idx == CW'(i))
          words[i] <= wr_data;
      end
    end
  end

  assign q = words;

endmodule

// File: rtl/mskaes_stream_io.sv
// Word-serial share transport for the masked AES-128 core: load key/pt words,
// pulse start, capture the shared ciphertext and stream it back out.
module mskaes_stream_io
  import mskaes_io_pkg::*;
#(
  parameter int d = 2,
  parameter int W = 32
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [W-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [W-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  input  logic             core_ready,
  output logic             core_valid_in,
  input  logic             core_cipher_valid,
  input  logic [128*d-1:0] core_sh_ciphertext,
  output logic [128*d-1:0] sh_key,
  output logic [128*d-1:0] sh_plaintext
);

  localparam int WN = calc_nw(d, W);
  localparam int CW = $clog2(WN);

  io_state_e            state;
  logic [CW-1:0]        cnt;
  logic                 last_word;
  logic                 in_hs;
  logic                 out_hs;
  logic [128*d-1:0]     ct_q;
  logic [WN-1:0][W-1:0] ct_words;

  assign last_word     = (cnt == CW'(WN - 1));
  assign in_ready      = (state == LD_KEY) || (state == LD_PT);
  assign out_valid     = (state == UNLOAD);
  assign core_valid_in = (state == START) && core_ready;
  assign busy          = (state != LD_KEY) || (cnt != '0);
  assign in_hs         = in_valid && in_ready;
  assign out_hs        = out_valid && out_ready;

  // cnt only moves on handshakes, so out_data holds under backpressure.
  assign ct_words = ct_q;
  assign out_data = ct_words[cnt];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= LD_KEY;
      cnt   <= '0;
    end else begin
      case (state)
        LD_KEY, LD_PT: begin
          if (in_hs) begin
            if (last_word) begin
              cnt   <= '0;
              state <= (state == LD_KEY) ? LD_PT : START;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        START:  if (core_ready) state <= WAIT;
        WAIT:   if (core_cipher_valid) state <= UNLOAD;
        UNLOAD: begin
          if (out_hs) begin
            if (last_word) begin
              cnt   <= '0;
              state <= LD_KEY;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= LD_KEY;
      endcase
    end
  end

  mskaes_word_reg #(.d(d), .W(W)) u_key (
    .clk     (clk),
    .nrst    (nrst),
    .wr_en   (in_hs && state == LD_KEY),
    .wr_idx  (cnt),
    .wr_data (in_data),
    .ld_en   (1'b0),
    .ld_data ('0),
    .q       (sh_key)
  );

  mskaes_word_reg #(.d(d), .W(W)) u_pt (
    .clk     (clk),
    .nrst    (nrst),
    .wr_en   (in_hs && state == LD_PT),
    .wr_idx  (cnt),
    .wr_data (in_data),
    .ld_en   (1'b0),
    .ld_data ('0),
    .q       (sh_plaintext)
  );

  mskaes_word_reg #(.d(d), .W(W)) u_ct (
    .clk     (clk),
    .nrst    (nrst),
    .wr_en   (1'b0),
    .wr_idx  ('0),
    .wr_data ('0),
    .ld_en   (state == WAIT && core_cipher_valid),
    .ld_data (core_sh_ciphertext),
    .q       (ct_q)
  );

endmodule

// File: tb/tb_mskaes_stream_io.sv
// Scoreboard bench: stub core with fixed latency, directed share streams.
module tb_mskaes_stream_io;
  localparam int D  = 2;
  localparam int W  = 32;
  localparam int NW = 128 * D / W;
  localparam int VB = 128 * D;
  localparam logic [127:0] KEY = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
  localparam logic [127:0] PT  = 128'h340737e0a29831318d305a88a8f64332;
  localparam logic [127:0] CT  = 128'h320b6a19978511dcfb09dc021d842539;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          busy;
  logic          core_ready = 1'b1;
  logic          core_valid_in;
  logic          core_cipher_valid;
  logic [VB-1:0] core_sh_ciphertext;
  logic [VB-1:0] sh_key;
  logic [VB-1:0] sh_plaintext;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mskaes_stream_io #(.d(D), .W(W)) dut (
    .clk(clk), .nrst(nrst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .core_ready(core_ready), .core_valid_in(core_valid_in),
    .core_cipher_valid(core_cipher_valid), .core_sh_ciphertext(core_sh_ciphertext),
    .sh_key(sh_key), .sh_plaintext(sh_plaintext)
  );

  // bit i share j lives at D*i+j
  function automatic logic [VB-1:0] share2(input logic [127:0] v, input logic [127:0] m);
    logic [VB-1:0] s;
    for (int i = 0; i < 128; i++) begin
      s[2*i]   = v[i] ^ m[i];
      s[2*i+1] = m[i];
    end
    return s;
  endfunction

  function automatic logic [127:0] unshare(input logic [VB-1:0] s);
    logic [127:0] v;
    for (int i = 0; i < 128; i++) v[i] = s[2*i] ^ s[2*i+1];
    return v;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string name, input logic [VB-1:0] act, input logic [VB-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Stub core: ciphertext valid ~30 cycles after start, sharing set by ct_mask.
  int            lat = 0;
  logic          stub_cv = 1'b0;
  logic [VB-1:0] ct_bus = '0;
  logic [127:0]  ct_mask = '0;
  logic          spur = 1'b0;
  logic [VB-1:0] junk = '0;
  logic [W-1:0]  exp_q[$];

  assign core_cipher_valid  = stub_cv | spur;
  assign core_sh_ciphertext = spur ? junk : ct_bus;

  always @(posedge clk) begin
    if (!nrst) lat = 0;
    else if (core_valid_in) lat = 30;
    else if (lat > 0) lat--;
    #1;
    stub_cv = (lat == 1);
    if (lat == 1) begin
      ct_bus = share2(CT, ct_mask);
      for (int k = 0; k < NW; k++) exp_q.push_back(ct_bus[W*k +: W]);
    end
  end

  bit bp_en = 1'b0;
  always @(posedge clk) begin
    #1;
    out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor / scoreboard
  int            hs_cnt = 0;
  bit            pend = 1'b0;
  bit            prev_stall = 1'b0;
  logic [W-1:0]  prev_data = '0;
  int            rx_k = 0;
  logic [VB-1:0] rx = '0;
  bit            chk_rdy = 1'b0;
  int            runs_done = 0;
  int            pulses = 0;
  logic [VB-1:0] exp_key = '0;
  logic [VB-1:0] exp_pt = '0;

  always @(negedge clk) begin
    if (!nrst) begin
      hs_cnt = 0; pend = 1'b0; prev_stall = 1'b0; rx_k = 0; chk_rdy = 1'b0;
    end else begin
      if (chk_rdy) begin
        chk("in_ready_after_unload", VB'(in_ready), VB'(1'b1));
        chk_rdy = 1'b0;
      end
      chk("core_valid_in", VB'(core_valid_in), VB'(pend && core_ready));
      if (core_valid_in) begin
        pend = 1'b0;
        pulses++;
      end
      if (busy && !in_ready) begin
        chk("sh_key_stable", sh_key, exp_key);
        chk("sh_plaintext_stable", sh_plaintext, exp_pt);
      end
      if (prev_stall) begin
        chk("out_valid_hold", VB'(out_valid), VB'(1'b1));
        chk("out_data_hold", VB'(out_data), VB'(prev_data));
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_out_word act=%h exp=none", out_data);
        end else begin
          chk("out_word", VB'(out_data), VB'(exp_q.pop_front()));
        end
        rx[W*rx_k +: W] = out_data;
        rx_k++;
        if (rx_k == NW) begin
          chk("recombined_ct", VB'(unshare(rx)), VB'(CT));
          rx_k = 0;
          runs_done++;
          chk_rdy = 1'b1;
        end
      end
      if (in_valid && in_ready) begin
        hs_cnt++;
        if (hs_cnt == 2*NW) begin
          hs_cnt = 0;
          pend = 1'b1;
        end
      end
    end
  end

  // Drivers: called and return at posedge+1 phase.
  task automatic send_word(input logic [W-1:0] w, input bit gaps);
    int n = 0;
    bit done = 1'b0;
    if (gaps) repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = w;
    while (!done) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      else if (++n > 200) begin
        total++; bad++;
        $display("FAIL in_handshake_timeout act=no_ready exp=ready");
        done = 1'b1;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic load(input logic [127:0] km, input logic [127:0] pm, input bit gaps, input bit sp);
    exp_key = share2(KEY, km);
    exp_pt  = share2(PT, pm);
    for (int k = 0; k < NW; k++) send_word(exp_key[W*k +: W], gaps);
    for (int k = 0; k < NW; k++) begin
      if (sp && k == 2) begin spur = 1'b1; junk = {rnd128(), rnd128()}; end
      send_word(exp_pt[W*k +: W], gaps);
      if (sp && k == 4) spur = 1'b0;
    end
    chk("sh_key_loaded", sh_key, exp_key);
    chk("sh_plaintext_loaded", sh_plaintext, exp_pt);
  endtask

  task automatic wait_runs(input int n);
    int c = 0;
    while (runs_done < n && c < 2000) begin @(negedge clk); c++; end
    chk("run_complete", VB'(runs_done >= n), VB'(1'b1));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [VB-1:0] part;
    nrst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sh_key", sh_key, '0);
    chk("rst_sh_plaintext", sh_plaintext, '0);
    chk("rst_out_valid", VB'(out_valid), '0);
    chk("rst_busy", VB'(busy), '0);
    chk("rst_core_valid_in", VB'(core_valid_in), '0);
    nrst = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", VB'(in_ready), VB'(1'b1));
    @(posedge clk); #1;

    // 1: nominal, share1 = 0 everywhere
    ct_mask = '0;
    load('0, '0, 1'b0, 1'b0);
    wait_runs(1);

    // 2: core_ready low for 10 cycles after load
    core_ready = 1'b0;
    ct_mask = rnd128();
    load(rnd128(), rnd128(), 1'b0, 1'b0);
    repeat (10) begin @(posedge clk); #1; end
    core_ready = 1'b1;
    wait_runs(2);

    // 3: input gaps and output backpressure
    bp_en = 1'b1;
    ct_mask = rnd128();
    load(rnd128(), rnd128(), 1'b1, 1'b0);
    wait_runs(3);
    bp_en = 1'b0;

    // 4: spurious core_cipher_valid while loading plaintext
    ct_mask = rnd128();
    load(rnd128(), rnd128(), 1'b0, 1'b1);
    wait_runs(4);

    // 5: reset after 5 key words
    part = share2(KEY, rnd128());
    for (int k = 0; k < 5; k++) send_word(part[W*k +: W], 1'b0);
    nrst = 1'b0;
    #2;
    chk("midrst_sh_key", sh_key, '0);
    chk("midrst_busy", VB'(busy), '0);
    chk("midrst_out_valid", VB'(out_valid), '0);
    chk("midrst_core_valid_in", VB'(core_valid_in), '0);
    @(posedge clk); #1;
    nrst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", VB'(in_ready), VB'(1'b1));
    @(posedge clk); #1;
    ct_mask = rnd128();
    load(rnd128(), rnd128(), 1'b0, 1'b0);
    wait_runs(5);

    // 6: back-to-back runs with fresh sharings
    ct_mask = rnd128();
    load(rnd128(), rnd128(), 1'b0, 1'b0);
    wait_runs(6);
    ct_mask = rnd128();
    load(rnd128(), rnd128(), 1'b0, 1'b0);
    wait_runs(7);

    chk("start_pulse_count", VB'(pulses), VB'(7));
    chk("scoreboard_drained", VB'(exp_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
